// File: rtl/microsequencer.sv
// Microsequencer: T-state counter, hardwired fetch words, {opcode,step} microcode sequencing, flag latch, jump resolve.
// Zero latency: every output is combinational from tstate/flags and inputs; step_en=0 freezes counter and flags.
module microsequencer #(
    parameter int          OPW    = 8,
    parameter int          TW     = 3,
    parameter logic [15:0] FETCH0 = 16'h0040,
    parameter logic [15:0] FETCH1 = 16'h3480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_en,
    input  logic [OPW-1:0]     opcode,
    output logic [OPW+TW-1:0]  rom_addr,
    input  logic [15:0]        rom_data,
    input  logic               alu_z,
    input  logic               alu_lt,
    input  logic               alu_c,
    output logic [15:0]        uinstr,
    output logic [TW-1:0]      tstate,
    output logic               jmp,
    output logic               instr_start
);

    typedef struct packed {
        logic z;
        logic lt;
        logic c;
    } flags_t;

    logic [TW-1:0] tstate_q, tstate_d;
    flags_t        flags_q, flags_d;
    logic          exec_step;
    logic          early_end;
    logic          fetch_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tstate_q <= '0;
            flags_q  <= '0;
        end else begin
            tstate_q <= tstate_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        exec_step  = (tstate_q > TW'(1));
        // An all-zero ROM word means the instruction is done; this cycle doubles as T0.
        early_end  = exec_step && (rom_data == 16'h0000);
        fetch_word = !exec_step || early_end;

        rom_addr = {opcode, tstate_q - TW'(2)};

        if (tstate_q == '0 || early_end) begin
            uinstr = FETCH0;
        end else if (tstate_q == TW'(1)) begin
            uinstr = FETCH1;
        end else begin
            uinstr = rom_data;
        end

        instr_start = (tstate_q == '0) || early_end;

        tstate_d = tstate_q;
        flags_d  = flags_q;
        if (step_en) begin
            tstate_d = early_end ? TW'(1) : tstate_q + TW'(1);
            if (uinstr[15]) begin
                flags_d = {alu_z, alu_lt, alu_c};
            end
        end

        // Uses the latched flags only, so a flag write lands one cycle before it can steer a jump.
        jmp = !fetch_word &&
              ((uinstr[5] & flags_q.c) |
               (uinstr[4] & flags_q.z) |
               (uinstr[3] & ~flags_q.z & ~flags_q.lt) |
               (uinstr[2] & flags_q.lt));
    end

    assign tstate = tstate_q;

endmodule
